ext_interleaver: RTL and testbench

Ping-pong extrinsic buffer between two SISO decoder passes of the turbo decoder. It accepts one 10-bit signed extrinsic LLR per accepted beat from the SISO output (`data_o`/`done`). It returns each full frame in QPP-interleaved or deinterleaved order, ready to drive the next SISO's `ext_i`. Two banks let frame n+1 be written while frame n drains.

---
 rtl/turbo_pkg.sv | 22 ++
 rtl/ext_interleaver_qpp_addr_gen.sv | 55 +++++
 rtl/ext_interleaver.sv | 166 ++++++++++++++++
 tb/tb_ext_interleaver.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turbo_pkg
// Description : Shared constants and types for the turbo decoder extrinsic path
// Revision    : 1.0 - initial release
// ============================================================================
package turbo_pkg;

  localparam int LLR_W     = 10;
  localparam int FRAME_LEN = 16;
  localparam int F1        = 3;
  localparam int F2        = 4;

  typedef enum logic {
    MODE_INTLV   = 1'b0,
    MODE_DEINTLV = 1'b1
  } intlv_mode_e;

  typedef logic signed [LLR_W-1:0] llr_t;

endpackage
`default_nettype wire

// File: rtl/ext_interleaver_qpp_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : qpp_addr_gen
// Description : Multiplier-free recursive QPP address generator
// Revision    : 1.0 - initial release
// ============================================================================
module qpp_addr_gen #(
  parameter int FRAME_LEN = 16,
  parameter int F1        = 3,
  parameter int F2        = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clr_i,
  input  logic                         adv_i,
  output logic [$clog2(FRAME_LEN)-1:0] pi_o
);

  localparam int              AW   = $clog2(FRAME_LEN);
  localparam logic [AW:0]     c_k  = (AW+1)'(FRAME_LEN);
  localparam logic [AW-1:0]   c_g0 = AW'((F1 + F2) % FRAME_LEN);
  localparam logic [AW-1:0]   c_dg = AW'((2 * F2) % FRAME_LEN);

  logic [AW-1:0] r_pi;
  logic [AW-1:0] r_g;
  logic [AW:0]   w_pi_sum;
  logic [AW:0]   w_g_sum;
  logic [AW-1:0] w_pi_nxt;
  logic [AW-1:0] w_g_nxt;

  // Both addends are below K, so one conditional subtract completes the mod.
  always_comb begin
    w_pi_sum = {1'b0, r_pi} + {1'b0, r_g};
    w_g_sum  = {1'b0, r_g} + {1'b0, c_dg};
    w_pi_nxt = (w_pi_sum >= c_k) ? AW'(w_pi_sum - c_k) : w_pi_sum[AW-1:0];
    w_g_nxt  = (w_g_sum >= c_k)  ? AW'(w_g_sum - c_k)  : w_g_sum[AW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pi <= '0;
      r_g  <= c_g0;
    end else if (clr_i) begin
      r_pi <= '0;
      r_g  <= c_g0;
    end else if (adv_i) begin
      r_pi <= w_pi_nxt;
      r_g  <= w_g_nxt;
    end
  end

  assign pi_o = r_pi;

endmodule
`default_nettype wire

// File: rtl/ext_interleaver.sv
`default_nettype none
// ============================================================================
// Module      : ext_interleaver
// Description : Ping-pong extrinsic buffer with QPP interleave/deinterleave.
//               Optional EXT_SCALE_EN applies a 0.75 extrinsic scale on read.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_interleaver #(
  parameter int FRAME_LEN = turbo_pkg::FRAME_LEN,
  parameter int F1        = turbo_pkg::F1,
  parameter int F2        = turbo_pkg::F2,
  parameter int LLR_W     = turbo_pkg::LLR_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  input  logic [LLR_W-1:0] in_ext_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [LLR_W-1:0] out_ext_o,
  output logic             frame_done_o
);

  import turbo_pkg::*;

  localparam int            AW     = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] c_last = AW'(FRAME_LEN - 1);

  logic [LLR_W-1:0] r_mem [2][FRAME_LEN];
  logic [1:0]       r_full;
  logic             r_wbank;
  logic             r_rbank;
  logic [AW-1:0]    r_wcnt;
  logic [AW-1:0]    r_rcnt;
  intlv_mode_e      r_mode [2];
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_frame_done;
  logic [LLR_W-1:0] r_out_ext;

  logic [AW-1:0]    w_wpi;
  logic [AW-1:0]    w_rpi;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic             w_wr_en;
  logic             w_wr_first;
  logic             w_wr_last;
  logic             w_rd_en;
  logic             w_rd_last;
  intlv_mode_e      w_wr_mode;
  logic [LLR_W-1:0] w_rd_data;
  logic [LLR_W-1:0] w_rd_scaled;

  assign in_ready_o = !r_full[r_wbank];
  assign w_wr_en    = in_valid_i & in_ready_o;
  assign w_wr_first = (r_wcnt == '0);
  assign w_wr_last  = (r_wcnt == c_last);
  // The first beat of a frame uses the live mode; later beats use the latched one.
  assign w_wr_mode  = w_wr_first ? intlv_mode_e'(mode_i) : r_mode[r_wbank];
  assign w_waddr    = (w_wr_mode == MODE_DEINTLV) ? w_wpi : r_wcnt;

  assign w_rd_en    = (!r_out_valid | out_ready_i) & r_full[r_rbank];
  assign w_rd_last  = (r_rcnt == c_last);
  assign w_raddr    = (r_mode[r_rbank] == MODE_INTLV) ? w_rpi : r_rcnt;
  assign w_rd_data  = r_mem[r_rbank][w_raddr];

  qpp_addr_gen #(
    .FRAME_LEN (FRAME_LEN),
    .F1        (F1),
    .F2        (F2)
  ) u_wr_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (w_wr_en & w_wr_last),
    .adv_i   (w_wr_en),
    .pi_o    (w_wpi)
  );

  qpp_addr_gen #(
    .FRAME_LEN (FRAME_LEN),
    .F1        (F1),
    .F2        (F2)
  ) u_rd_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (w_rd_en & w_rd_last),
    .adv_i   (w_rd_en),
    .pi_o    (w_rpi)
  );

`ifdef EXT_SCALE_EN
  logic signed [LLR_W+1:0] w_x;
  logic signed [LLR_W+1:0] w_x3;

  always_comb begin
    w_x         = {{2{w_rd_data[LLR_W-1]}}, w_rd_data};
    w_x3        = w_x + (w_x <<< 1);
    w_rd_scaled = LLR_W'(w_x3 >>> 2);
  end
`else
  assign w_rd_scaled = w_rd_data;
`endif

  // Storage carries no reset; the full flags decide what is meaningful.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wbank][w_waddr] <= in_ext_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_full       <= '0;
      r_wbank      <= 1'b0;
      r_rbank      <= 1'b0;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_mode[0]    <= MODE_INTLV;
      r_mode[1]    <= MODE_INTLV;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_ext    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_out_valid & out_ready_i & r_out_last;

      if (w_wr_en) begin
        if (w_wr_first) begin
          r_mode[r_wbank] <= w_wr_mode;
        end
        if (w_wr_last) begin
          r_full[r_wbank] <= 1'b1;
          r_wbank         <= ~r_wbank;
          r_wcnt          <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end

      // Write and read always target different banks, so flag updates never collide.
      if (w_rd_en) begin
        r_out_ext   <= w_rd_scaled;
        r_out_valid <= 1'b1;
        r_out_last  <= w_rd_last;
        if (w_rd_last) begin
          r_full[r_rbank] <= 1'b0;
          r_rbank         <= ~r_rbank;
          r_rcnt          <= '0;
        end else begin
          r_rcnt <= r_rcnt + 1'b1;
        end
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid_o  = r_out_valid;
  assign out_ext_o    = r_out_ext;
  assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ext_interleaver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_interleaver
// Description : Directed self-checking bench for ext_interleaver
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_interleaver;

  localparam int LLR_W = 10;
  localparam int K     = 16;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             mode_i;
  logic             in_valid_i;
  logic [LLR_W-1:0] in_ext_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [LLR_W-1:0] out_ext_o;
  logic             frame_done_o;

  always #5 clk_i = ~clk_i;

  ext_interleaver dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .mode_i       (mode_i),
    .in_valid_i   (in_valid_i),
    .in_ext_i     (in_ext_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_ext_o    (out_ext_o),
    .frame_done_o (frame_done_o)
  );

  // Hand-computed pi(i) = (3i + 4i^2) mod 16
  int pi_tab [K] = '{0, 7, 6, 13, 12, 3, 2, 9, 8, 15, 14, 5, 4, 11, 10, 1};

  int               checks = 0;
  int               errors = 0;
  int               exp_q [$];
  int               popped = 0;
  int               done_cnt = 0;
  bit               done_pend = 1'b0;
  bit               stall_prev = 1'b0;
  logic [LLR_W-1:0] held = '0;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int scale(input int x);
`ifdef EXT_SCALE_EN
    return (3 * x) >>> 2;
`else
    return x;
`endif
  endfunction

  // Output monitor: data order, stall stability, frame_done timing
  always @(negedge clk_i) begin
    if (rst_n_i !== 1'b1) begin
      exp_q.delete();
      popped     = 0;
      done_pend  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (done_pend || frame_done_o) check("frame_done", frame_done_o, done_pend);
      if (frame_done_o) done_cnt++;
      done_pend = 1'b0;
      if (stall_prev) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_data", $signed(out_ext_o), $signed(held));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", out_valid_o, 0);
        end else begin
          check("data", $signed(out_ext_o), exp_q.pop_front());
          popped++;
          if (popped == K) begin
            popped    = 0;
            done_pend = 1'b1;
          end
        end
      end
      stall_prev = out_valid_o && !out_ready_i;
      held       = out_ext_o;
    end
  end

  task automatic write_beat(input int v, input logic m);
    int t;
    t = 0;
    @(negedge clk_i);
    while (!in_ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (!in_ready_o) check("in_ready_timeout", in_ready_o, 1);
    in_valid_i = 1'b1;
    in_ext_i   = v[LLR_W-1:0];
    mode_i     = m;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int v [K], input int o [K], input logic m, input bit flip);
    int tmp [K];
    for (int i = 0; i < K; i++) begin
      if (m == 1'b0) tmp[i] = o[pi_tab[i]];
      else           tmp[pi_tab[i]] = o[i];
    end
    for (int i = 0; i < K; i++) exp_q.push_back(tmp[i]);
    for (int i = 0; i < K; i++) write_beat(v[i], (flip && i > 0) ? ~m : m);
  endtask

  task automatic send_scaled(input int v [K], input logic m, input bit flip);
    int o [K];
    for (int i = 0; i < K; i++) o[i] = scale(v[i]);
    send_frame(v, o, m, flip);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready_o, 1);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_out_ext"}, out_ext_o, 0);
    check({tag, "_frame_done"}, frame_done_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v [K];
    int o [K];
    int d0;
    int gaps;
    int first_rdy;

    rst_n_i     = 1'b0;
    mode_i      = 1'b0;
    in_valid_i  = 1'b0;
    in_ext_i    = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_n_i = 1'b1;

    // Interleave 0..15
    for (int i = 0; i < K; i++) v[i] = i;
    d0 = done_cnt;
    send_scaled(v, 1'b0, 1'b0);
    wait_drain();
    check("intlv_done_cnt", done_cnt - d0, 1);

    // Deinterleave the interleaved sequence back to 0..15
    for (int i = 0; i < K; i++) v[i] = pi_tab[i];
    d0 = done_cnt;
    send_scaled(v, 1'b1, 1'b0);
    wait_drain();
    check("deintlv_done_cnt", done_cnt - d0, 1);

    // Three frames with downstream stalled
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    d0 = done_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < K; i++) v[i] = 100 + 16 * f + i;
      send_scaled(v, 1'b0, 1'b0);
    end
    @(negedge clk_i);
    check("both_full_in_ready", in_ready_o, 0);
    repeat (5) @(negedge clk_i);
    check("stalled_in_ready", in_ready_o, 0);
    check("stalled_valid", out_valid_o, 1);
    check("stalled_head", $signed(out_ext_o), scale(100));
    for (int i = 0; i < K; i++) v[i] = 132 + i;
    gaps      = 0;
    first_rdy = -1;
    fork
      begin
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 3 * K; k++) begin
          @(negedge clk_i);
          if (!out_valid_o) gaps++;
          if (in_ready_o && first_rdy < 0) first_rdy = k;
        end
      end
      send_scaled(v, 1'b0, 1'b0);
    join
    check("drain_gaps", gaps, 0);
    check("bank_free_cycle", first_rdy, 15);
    wait_drain();
    check("three_done_cnt", done_cnt - d0, 3);

    // Random downstream stalls, mode toggled mid-frame
    for (int i = 0; i < K; i++) v[i] = i * 53 - 400;
    fork
      send_scaled(v, 1'b0, 1'b1);
      begin
        for (int t = 0; t < 400 && (t < 20 || exp_q.size() != 0); t++) begin
          @(posedge clk_i);
          #1;
          out_ready_i = 1'($urandom_range(0, 1));
        end
        out_ready_i = 1'b1;
      end
    join
    wait_drain();

    // Reset in the middle of a write
    for (int i = 0; i < 9; i++) write_beat(200 + i, 1'b0);
    #3;
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("rst_write");
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // Reset in the middle of a drain
    for (int i = 0; i < K; i++) v[i] = 300 + i;
    send_scaled(v, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    check("pre_rst_valid", out_valid_o, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("rst_drain");
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // Fresh frame after reset
    for (int i = 0; i < K; i++) v[i] = 15 - i;
    d0 = done_cnt;
    send_scaled(v, 1'b0, 1'b0);
    wait_drain();
    check("post_rst_done_cnt", done_cnt - d0, 1);

    // Extreme values through the optional scaler
    v = '{-100, 101, -101, 511, -512, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    for (int i = 0; i < K; i++) o[i] = scale(v[i]);
`ifdef EXT_SCALE_EN
    o[0] = -75; o[1] = 75; o[2] = -76; o[3] = 383; o[4] = -384;
`else
    o[0] = -100; o[1] = 101; o[2] = -101; o[3] = 511; o[4] = -512;
`endif
    send_frame(v, o, 1'b1, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
